// File: rtl/rgb_led_pkg.sv
// Shared types and helpers for the RGB LED pattern sequencer.
package rgb_led_pkg;

    localparam int CH_W    = 8;
    localparam int COLOR_W = 3 * CH_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FADE,
        ST_HOLD
    } state_e;

    // Move one 8-bit channel a single LSB toward its target; saturates at the target.
    function automatic logic [CH_W-1:0] ch_toward(
        input logic [CH_W-1:0] cur,
        input logic [CH_W-1:0] tgt
    );
        logic [CH_W-1:0] res;
        res = cur;
        if (cur < tgt) begin
            res = cur + CH_W'(1);
        end else if (cur > tgt) begin
            res = cur - CH_W'(1);
        end
        return res;
    endfunction

    // Apply ch_toward to each of the R, G and B channels independently.
    function automatic logic [COLOR_W-1:0] color_toward(
        input logic [COLOR_W-1:0] cur,
        input logic [COLOR_W-1:0] tgt
    );
        logic [COLOR_W-1:0] res;
        res = cur;
        for (int ch = 0; ch < 3; ch++) begin
            res[ch*CH_W +: CH_W] = ch_toward(cur[ch*CH_W +: CH_W], tgt[ch*CH_W +: CH_W]);
        end
        return res;
    endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV enabled clocks, clearable.
module rgb_tick_gen #(
    parameter int TICK_DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int               CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);

    // Count 0..TICK_DIV-1 while enabled; a clear restarts the period from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = i_enable && !i_clear && w_at_last;

endmodule

// File: rtl/rgb_led_sequencer.sv
// Pattern sequencer in front of RgbLed: plays stored colour/dwell/blink/fade steps.
module rgb_led_sequencer
    import rgb_led_pkg::*;
#(
    parameter  int N_STEPS  = 8,
    parameter  int TICK_DIV = 27000,
    parameter  int DWELL_W  = 16,
    localparam int IDX_W    = $clog2(N_STEPS),
    localparam int NUM_W    = IDX_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [NUM_W-1:0]   num_steps,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic               wr_blink,
    input  logic               wr_fade,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               blink_out,
    output logic               busy,
    output logic [IDX_W-1:0]   step_idx,
    output logic               done
);

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [DWELL_W-1:0] dwell;
        logic               blink;
        logic               fade;
    } step_t;

    localparam logic [NUM_W-1:0] MAX_STEPS = NUM_W'(N_STEPS);

    step_t              r_table [N_STEPS];
    state_e             r_state;
    state_e             w_next_state;
    logic [IDX_W-1:0]   r_step_idx;
    logic [NUM_W-1:0]   r_num_steps;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic [COLOR_W-1:0] r_tgt_color;
    logic               r_hold_blink;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_blink;
    logic               r_done;

    step_t              w_rd_step;
    logic               w_busy;
    logic               w_tick;
    logic               w_start_ok;
    logic [NUM_W-1:0]   w_num_clamped;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_dwell_done;
    logic               w_last_step;
    logic               w_fade_done;

    assign w_busy        = (r_state != ST_IDLE);
    assign w_rd_step     = r_table[r_step_idx];
    assign w_start_ok    = start && !stop && (num_steps != '0) && (r_state == ST_IDLE);
    assign w_num_clamped = (num_steps > MAX_STEPS) ? MAX_STEPS : num_steps;
    assign w_dwell_eff   = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
    assign w_dwell_done  = w_tick && (r_dwell_cnt == w_dwell_eff - DWELL_W'(1));
    assign w_last_step   = ({1'b0, r_step_idx} == r_num_steps - NUM_W'(1));
    assign w_fade_done   = (r_rgb == r_tgt_color);

    rgb_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_start_ok),
        .i_enable (w_busy),
        .o_tick   (w_tick)
    );

    // Host write port into the step table; a same-cycle LOAD still sees the old entry.
    // NOTE: the table has no reset -- it is always written before playback, and a reset would prevent RAM mapping.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= '{color: wr_color, dwell: wr_dwell, blink: wr_blink, fade: wr_fade};
        end
    end

    // State register.
    // NOTE: sequential blocks use <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; stop overrides every other condition.
    // NOTE: the default assignment first means no path leaves w_next_state unassigned, so no latch.
    always_comb begin
        w_next_state = r_state;
        if (stop) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start_ok) w_next_state = ST_LOAD;
                ST_LOAD: w_next_state = w_rd_step.fade ? ST_FADE : ST_HOLD;
                ST_FADE: if (w_fade_done) w_next_state = ST_HOLD;
                ST_HOLD: begin
                    if (w_dwell_done) begin
                        w_next_state = (w_last_step && !loop_en) ? ST_IDLE : ST_LOAD;
                    end
                end
            endcase
        end
    end

    // Playback datapath: output colour/blink, step index, dwell counter and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb        <= '0;
            r_blink      <= 1'b0;
            r_done       <= 1'b0;
            r_step_idx   <= '0;
            r_num_steps  <= '0;
            r_dwell_cnt  <= '0;
            r_dwell      <= '0;
            r_tgt_color  <= '0;
            r_hold_blink <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_rgb      <= '0;
                r_blink    <= 1'b0;
                r_step_idx <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_rgb      <= '0;
                        r_blink    <= 1'b0;
                        r_step_idx <= '0;
                        if (w_start_ok) begin
                            r_num_steps <= w_num_clamped;
                        end
                    end
                    ST_LOAD: begin
                        // Latch the step so host rewrites only affect its next LOAD.
                        r_tgt_color  <= w_rd_step.color;
                        r_dwell      <= w_rd_step.dwell;
                        r_hold_blink <= w_rd_step.blink;
                        r_dwell_cnt  <= '0;
                        if (w_rd_step.fade) begin
                            r_blink <= 1'b0;
                        end else begin
                            r_rgb   <= w_rd_step.color;
                            r_blink <= w_rd_step.blink;
                        end
                    end
                    ST_FADE: begin
                        if (w_fade_done) begin
                            r_blink     <= r_hold_blink;
                            r_dwell_cnt <= '0;
                        end else if (w_tick) begin
                            r_rgb <= color_toward(r_rgb, r_tgt_color);
                        end
                    end
                    ST_HOLD: begin
                        if (w_dwell_done) begin
                            if (w_last_step) begin
                                if (loop_en) begin
                                    r_step_idx <= '0;
                                end else begin
                                    r_done <= 1'b1;
                                end
                            end else begin
                                r_step_idx <= r_step_idx + IDX_W'(1);
                            end
                        end else if (w_tick) begin
                            r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign rgb_out   = r_rgb;
    assign blink_out = r_blink;
    assign busy      = w_busy;
    assign step_idx  = r_step_idx;
    assign done      = r_done;

endmodule
